// File: rtl/stack_game_ctrl.sv
// stack_game_ctrl: sequencer for the stacking game.
// Gates the block mover, latches the drop position and computes the overlap
// with the layer below. Each new layer goes to the draw engine over a req/ack
// handshake. Also tracks the level and the win/game-over status.
module stack_game_ctrl #(
   parameter int X_MAX      = 144,
   parameter int INIT_WIDTH = 16,
   parameter int Y_BASE     = 112,
   parameter int LAYER_H    = 8,
   parameter int MAX_LEVEL  = 14
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start,
   input  logic       drop,
   input  logic       frame_tick,
   input  logic [7:0] curr_x,
   output logic       move_en,
   output logic [7:0] blk_width,
   output logic [7:0] base_x,
   output logic [3:0] level,
   output logic       draw_req,
   input  logic       draw_ack,
   output logic [7:0] draw_x,
   output logic [6:0] draw_y,
   output logic [7:0] draw_w,
   output logic       game_over,
   output logic       win
);

   localparam logic [7:0] BASE_X0 = 8'(X_MAX / 2);
   localparam logic [7:0] INIT_W  = 8'(INIT_WIDTH);
   localparam logic [6:0] Y0      = 7'(Y_BASE);
   localparam logic [3:0] LVL_WIN = 4'(MAX_LEVEL);

   typedef enum logic [2:0] {
      IDLE, FDRAW, ARM, MOVE, CHECK, DRAW, NEXT, OVER
   } state_t;

   state_t     state, state_nxt;
   logic       drop_d;
   logic       drop_edge;
   logic [7:0] lx;
   logic [8:0] ovl_lo, ovl_hi;
   logic       ovl_ok;
   logic [3:0] level_inc;
   logic       draw_done;

   function automatic logic [8:0] max9(input logic [8:0] a, input logic [8:0] b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic [8:0] min9(input logic [8:0] a, input logic [8:0] b);
      return (a < b) ? a : b;
   endfunction

   // Top row of the layer that sits one step above the given level.
   function automatic logic [6:0] layer_y(input logic [3:0] lvl);
      int y;
      y = Y_BASE - (int'(lvl) + 1) * LAYER_H;
      return 7'(y);
   endfunction

   // Both the dropped block and the layer below share the same width, so the
   // overlap is [max(left edges), min(right edges)); empty when hi <= lo.
   always_comb begin
      ovl_lo    = max9({1'b0, lx}, {1'b0, base_x});
      ovl_hi    = min9({1'b0, lx} + {1'b0, blk_width}, {1'b0, base_x} + {1'b0, blk_width});
      ovl_ok    = (ovl_hi > ovl_lo);
      drop_edge = drop & ~drop_d;
      level_inc = level + 4'd1;
      draw_done = draw_ack & draw_req;
   end

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next-state logic and the mover enable.
   always_comb begin
      state_nxt = state;
      move_en   = 1'b0;
      case (state)
         IDLE:    if (start) state_nxt = FDRAW;
         FDRAW:   if (draw_done) state_nxt = ARM;
         ARM:     if (frame_tick) state_nxt = MOVE;
         MOVE: begin
            move_en = 1'b1;
            if (drop_edge) state_nxt = CHECK;
         end
         CHECK:   state_nxt = ovl_ok ? DRAW : OVER;
         DRAW:    if (draw_done) state_nxt = NEXT;
         NEXT:    state_nxt = (level_inc == LVL_WIN) ? OVER : ARM;
         OVER:    if (start) state_nxt = FDRAW;
         default: state_nxt = IDLE;
      endcase
   end

   // Drop position captured on the accepted edge; consumed only in CHECK.
   always_ff @(posedge clk) begin
      if (state == MOVE && drop_edge) lx <= curr_x;
   end

   // Game status, settled-layer geometry and the draw handshake.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         drop_d    <= 1'b0;
         base_x    <= BASE_X0;
         blk_width <= INIT_W;
         level     <= 4'd0;
         game_over <= 1'b0;
         win       <= 1'b0;
         draw_req  <= 1'b0;
         draw_x    <= 8'd0;
         draw_y    <= 7'd0;
         draw_w    <= 8'd0;
      end else begin
         drop_d <= drop;
         case (state)
            IDLE, OVER: begin
               if (start) begin
                  base_x    <= BASE_X0;
                  blk_width <= INIT_W;
                  level     <= 4'd0;
                  game_over <= 1'b0;
                  win       <= 1'b0;
                  draw_x    <= BASE_X0;
                  draw_y    <= Y0;
                  draw_w    <= INIT_W;
                  draw_req  <= 1'b1;
               end
            end
            FDRAW, DRAW: begin
               if (draw_done) draw_req <= 1'b0;
            end
            CHECK: begin
               if (ovl_ok) begin
                  draw_x   <= ovl_lo[7:0];
                  draw_y   <= layer_y(level);
                  draw_w   <= 8'(ovl_hi - ovl_lo);
                  draw_req <= 1'b1;
               end else begin
                  game_over <= 1'b1;
                  win       <= 1'b0;
               end
            end
            NEXT: begin
               level     <= level_inc;
               base_x    <= draw_x;
               blk_width <= draw_w;
               if (level_inc == LVL_WIN) begin
                  game_over <= 1'b1;
                  win       <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_stack_game_ctrl.sv
// tb_stack_game_ctrl: directed bench for the stacking game sequencer.
module tb_stack_game_ctrl;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       start = 1'b0;
   logic       drop = 1'b0;
   logic       frame_tick = 1'b0;
   logic [7:0] curr_x = 8'd0;
   logic       draw_ack = 1'b0;
   logic       move_en, draw_req, game_over, win;
   logic [7:0] blk_width, base_x, draw_x, draw_w;
   logic [3:0] level;
   logic [6:0] draw_y;

   int pass_cnt = 0;
   int total_cnt = 0;

   stack_game_ctrl dut (
      .clk(clk), .resetn(resetn), .start(start), .drop(drop),
      .frame_tick(frame_tick), .curr_x(curr_x), .move_en(move_en),
      .blk_width(blk_width), .base_x(base_x), .level(level),
      .draw_req(draw_req), .draw_ack(draw_ack), .draw_x(draw_x),
      .draw_y(draw_y), .draw_w(draw_w), .game_over(game_over), .win(win)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] cx;
      logic       ovr;
      logic [7:0] ex;
      logic [7:0] ew;
   } vec_t;

   vec_t vt[8];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic do_reset();
      start = 0; drop = 0; frame_tick = 0; draw_ack = 0; curr_x = 0;
      resetn = 0;
      step(); step();
      resetn = 1;
      step();
   endtask

   // From IDLE: start, accept the foundation draw, then a frame tick into MOVE.
   task automatic start_to_move();
      start = 1; step(); start = 0;
      chk("fdraw_req", draw_req, 1);
      chk("fdraw_x", draw_x, 72);
      chk("fdraw_y", draw_y, 112);
      chk("fdraw_w", draw_w, 16);
      draw_ack = 1; step(); draw_ack = 0;
      chk("arm_req_low", draw_req, 0);
      chk("arm_move_en", move_en, 0);
      frame_tick = 1; step(); frame_tick = 0;
      chk("move_en_on", move_en, 1);
   endtask

   initial begin
      logic stable;
      vt[0] = '{cx: 8'd76,  ovr: 1'b0, ex: 8'd76, ew: 8'd12};
      vt[1] = '{cx: 8'd72,  ovr: 1'b0, ex: 8'd72, ew: 8'd16};
      vt[2] = '{cx: 8'd57,  ovr: 1'b0, ex: 8'd72, ew: 8'd1};
      vt[3] = '{cx: 8'd87,  ovr: 1'b0, ex: 8'd87, ew: 8'd1};
      vt[4] = '{cx: 8'd60,  ovr: 1'b0, ex: 8'd72, ew: 8'd4};
      vt[5] = '{cx: 8'd88,  ovr: 1'b1, ex: 8'd0,  ew: 8'd0};
      vt[6] = '{cx: 8'd56,  ovr: 1'b1, ex: 8'd0,  ew: 8'd0};
      vt[7] = '{cx: 8'd144, ovr: 1'b1, ex: 8'd0,  ew: 8'd0};

      // Reset values.
      do_reset();
      chk("rst_move_en", move_en, 0);
      chk("rst_req", draw_req, 0);
      chk("rst_level", level, 0);
      chk("rst_base_x", base_x, 72);
      chk("rst_width", blk_width, 16);
      chk("rst_draw_x", draw_x, 0);
      chk("rst_draw_w", draw_w, 0);
      chk("rst_over", game_over, 0);
      chk("rst_win", win, 0);

      // Single drop from a fresh game, table driven.
      for (int i = 0; i < 8; i++) begin
         do_reset();
         start_to_move();
         curr_x = vt[i].cx;
         drop = 1; step();
         chk("check_move_en", move_en, 0);
         chk("check_req", draw_req, 0);
         step(); drop = 0;
         if (vt[i].ovr) begin
            chk("miss_req", draw_req, 0);
            chk("miss_over", game_over, 1);
            chk("miss_win", win, 0);
            chk("miss_move_en", move_en, 0);
            step();
            chk("miss_held_over", game_over, 1);
            chk("miss_held_level", level, 0);
         end else begin
            chk("hit_req", draw_req, 1);
            chk("hit_x", draw_x, vt[i].ex);
            chk("hit_y", draw_y, 104);
            chk("hit_w", draw_w, vt[i].ew);
            chk("hit_over", game_over, 0);
            draw_ack = 1; step(); draw_ack = 0;
            chk("ack_req_low", draw_req, 0);
            step();
            chk("next_level", level, 1);
            chk("next_base_x", base_x, vt[i].ex);
            chk("next_width", blk_width, vt[i].ew);
            chk("next_move_en", move_en, 0);
         end
      end

      // Fourteen exact drops reach the win, then start restarts the game.
      do_reset();
      start_to_move();
      for (int i = 0; i < 14; i++) begin
         if (i > 0) begin
            frame_tick = 1; step(); frame_tick = 0;
         end
         curr_x = 8'd72;
         drop = 1; step(); drop = 0; step();
         chk("win_req", draw_req, 1);
         chk("win_y", draw_y, 112 - 8 * (i + 1));
         draw_ack = 1; step(); draw_ack = 0; step();
      end
      chk("win_level", level, 14);
      chk("win_over", game_over, 1);
      chk("win_flag", win, 1);
      chk("win_last_y", draw_y, 0);
      chk("win_move_en", move_en, 0);
      start = 1; step(); start = 0;
      chk("restart_level", level, 0);
      chk("restart_over", game_over, 0);
      chk("restart_win", win, 0);
      chk("restart_req", draw_req, 1);
      chk("restart_y", draw_y, 112);
      chk("restart_base_x", base_x, 72);

      // Slow acknowledge keeps the rectangle stable; reset aborts the draw.
      do_reset();
      start_to_move();
      curr_x = 8'd76;
      drop = 1; step(); drop = 0; step();
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (!draw_req || draw_x != 76 || draw_y != 104 || draw_w != 12) stable = 1'b0;
      end
      chk("slow_ack_stable", stable, 1);
      resetn = 0;
      #2;
      chk("async_rst_req", draw_req, 0);
      chk("async_rst_level", level, 0);
      step();
      resetn = 1;
      step();
      chk("post_rst_move_en", move_en, 0);

      // Drops outside MOVE, a held drop across ARM->MOVE and a stray start are ignored.
      do_reset();
      start = 1; step(); start = 0;
      draw_ack = 1; step(); draw_ack = 0;
      drop = 1; step(); drop = 0; step();
      chk("arm_drop_ignored", move_en, 0);
      drop = 1;
      frame_tick = 1; step(); frame_tick = 0;
      step(); step();
      chk("held_drop_move_en", move_en, 1);
      chk("held_drop_req", draw_req, 0);
      start = 1; step(); start = 0; step();
      chk("start_ignored", move_en, 1);
      drop = 0; step();
      curr_x = 8'd72;
      drop = 1; step(); step(); drop = 0;
      chk("fresh_edge_req", draw_req, 1);
      chk("fresh_edge_w", draw_w, 16);
      chk("fresh_edge_x", draw_x, 72);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
